strip_tile_scheduler: RTL and testbench

Sequences the tile line-buffer BRAM: accepts a raster pixel stream, writes it into two ping-pong strip banks (each TILE_HEIGHT lines × IMG_WIDTH), then reads each full strip back in 16×16 tile order.
- Generates all BRAM write/read control plus tile/frame framing flags.
- Sits between the camera/raster source and the BRAM interface; it is the only master of the buffer.

---
 rtl/strip_tile_pkg.sv | 33 +++
 rtl/strip_tile_scheduler_if.sv | 32 +++
 rtl/tile_rd_addr_gen.sv | 65 ++++++
 rtl/strip_tile_scheduler.sv | 176 +++++++++++++++++
 tb/tb_strip_tile_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/strip_tile_pkg.sv
// Shared constants, read FSM encoding and address helpers for the strip/tile line buffer.
package strip_tile_pkg;

    localparam int unsigned IMG_WIDTH_DEF   = 640;
    localparam int unsigned IMG_HEIGHT_DEF  = 480;
    localparam int unsigned TILE_WIDTH_DEF  = 16;
    localparam int unsigned TILE_HEIGHT_DEF = 16;

    // Pixels per strip bank, tiles per strip, strips per frame at the default geometry
    localparam int unsigned STRIP = IMG_WIDTH_DEF * TILE_HEIGHT_DEF;
    localparam int unsigned TPS   = IMG_WIDTH_DEF / TILE_WIDTH_DEF;
    localparam int unsigned SPF   = IMG_HEIGHT_DEF / TILE_HEIGHT_DEF;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_ACTIVE = 1'b1
    } rdState_t;

    // Linear buffer address of (row, col) inside a strip bank
    function automatic int unsigned bufAddr(input int unsigned bank,
                                            input int unsigned stripSize,
                                            input int unsigned row,
                                            input int unsigned width,
                                            input int unsigned col);
        return bank * stripSize + row * width + col;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit
    function automatic int unsigned cntW(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/strip_tile_scheduler_if.sv
// Pixel-in / BRAM-control-out bundle of the strip tile scheduler.
interface strip_tile_scheduler_if #(
    parameter int unsigned ADDR_W = 15
);
    logic              iPixValid;
    logic              iSof;
    logic              oPixReady;
    logic              iOutReady;
    logic              oWrEn;
    logic [ADDR_W-1:0] oWrAddr;
    logic              oRdEn;
    logic [ADDR_W-1:0] oRdAddr;
    logic              oRdValid;
    logic              oTileStart;
    logic              oTileLast;
    logic              oFrameDone;
    logic              oSofErr;

    // Scheduler side
    modport master (
        input  iPixValid, iSof, iOutReady,
        output oPixReady, oWrEn, oWrAddr, oRdEn, oRdAddr,
               oRdValid, oTileStart, oTileLast, oFrameDone, oSofErr
    );

    // Source / consumer / BRAM side
    modport slave (
        output iPixValid, iSof, iOutReady,
        input  oPixReady, oWrEn, oWrAddr, oRdEn, oRdAddr,
               oRdValid, oTileStart, oTileLast, oFrameDone, oSofErr
    );
endinterface

// File: rtl/tile_rd_addr_gen.sv
// Walks a full strip bank in 16x16 tile order and tags tile/strip boundaries.
module tile_rd_addr_gen
    import strip_tile_pkg::*;
#(
    parameter int unsigned IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int unsigned TILE_WIDTH  = TILE_WIDTH_DEF,
    parameter int unsigned TILE_HEIGHT = TILE_HEIGHT_DEF,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iAdvance,
    input  logic              iBank,
    output logic [ADDR_W-1:0] oRdAddr,
    output logic              oTileStart,
    output logic              oTileLast,
    output logic              oStripLast
);

    localparam int unsigned stripSize     = IMG_WIDTH * TILE_HEIGHT;
    localparam int unsigned tilesPerStrip = IMG_WIDTH / TILE_WIDTH;
    localparam int unsigned C_W           = cntW(TILE_WIDTH);
    localparam int unsigned R_W           = cntW(TILE_HEIGHT);
    localparam int unsigned TX_W          = cntW(tilesPerStrip);

    logic [C_W-1:0]  c;
    logic [R_W-1:0]  r;
    logic [TX_W-1:0] tx;
    logic            cLast;
    logic            rLast;
    logic            txLast;

    assign cLast  = (c  == C_W'(TILE_WIDTH - 1));
    assign rLast  = (r  == R_W'(TILE_HEIGHT - 1));
    assign txLast = (tx == TX_W'(tilesPerStrip - 1));

    assign oTileStart = (c == '0) && (r == '0);
    assign oTileLast  = cLast && rLast;
    assign oStripLast = cLast && rLast && txLast;

    assign oRdAddr = ADDR_W'(bufAddr(32'(iBank), stripSize, 32'(r), IMG_WIDTH,
                                     32'(tx) * TILE_WIDTH + 32'(c)));

    // Column inside tile, then row inside tile, then tile index; advance per issued read
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            c  <= '0;
            r  <= '0;
            tx <= '0;
        end else if (iAdvance) begin
            if (!cLast) begin
                c <= c + C_W'(1);
            end else begin
                c <= '0;
                if (!rLast) begin
                    r <= r + R_W'(1);
                end else begin
                    r  <= '0;
                    tx <= txLast ? '0 : tx + TX_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/strip_tile_scheduler.sv
// Ping-pong strip buffer sequencer: raster writes in, 16x16 tile-ordered reads out.
module strip_tile_scheduler
    import strip_tile_pkg::*;
#(
    parameter int unsigned IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter int unsigned TILE_WIDTH  = TILE_WIDTH_DEF,
    parameter int unsigned TILE_HEIGHT = TILE_HEIGHT_DEF,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned ADDR_W      = 15
) (
    input  logic                   iClk,
    input  logic                   iRst,
    strip_tile_scheduler_if.master bus
);

    localparam int unsigned stripSize      = IMG_WIDTH * TILE_HEIGHT;
    localparam int unsigned stripsPerFrame = IMG_HEIGHT / TILE_HEIGHT;
    localparam int unsigned COL_W          = cntW(IMG_WIDTH);
    localparam int unsigned LINE_W         = cntW(TILE_HEIGHT);
    localparam int unsigned SC_W           = cntW(stripsPerFrame);

    logic [COL_W-1:0]  col;
    logic [LINE_W-1:0] line;
    logic [SC_W-1:0]   wStrip;
    logic [SC_W-1:0]   rStrip;
    logic              wBank;
    logic              rBank;
    logic [1:0]        bankFull;
    logic [1:0]        bankFullNext;
    logic              sofErr;
    rdState_t          rState;

    logic              pixReady;
    logic              accept;
    logic              posZero;
    logic [COL_W-1:0]  colEff;
    logic [LINE_W-1:0] lineEff;
    logic [SC_W-1:0]   wStripEff;
    logic              wrStripEnd;

    logic              rdEn;
    logic              rdFinal;
    logic              tileStart;
    logic              tileLast;
    logic              stripLast;
    logic              frameLast;
    logic [3:0]        pipe [RD_LATENCY];

    // A start-of-frame pixel lands at (0,0) of the current write bank
    assign pixReady   = !bankFull[wBank];
    assign accept     = bus.iPixValid && pixReady;
    assign posZero    = (col == '0) && (line == '0);
    assign colEff     = bus.iSof ? '0 : col;
    assign lineEff    = bus.iSof ? '0 : line;
    assign wStripEff  = bus.iSof ? '0 : wStrip;
    assign wrStripEnd = (lineEff == LINE_W'(TILE_HEIGHT - 1)) && (colEff == COL_W'(IMG_WIDTH - 1));

    assign bus.oPixReady = pixReady;
    assign bus.oWrEn     = accept;
    assign bus.oWrAddr   = ADDR_W'(bufAddr(32'(wBank), stripSize, 32'(lineEff), IMG_WIDTH, 32'(colEff)));
    assign bus.oSofErr   = sofErr;

    // Raster write position, strip count and sticky misplaced-SOF flag
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            col    <= '0;
            line   <= '0;
            wStrip <= '0;
            wBank  <= 1'b0;
            sofErr <= 1'b0;
        end else if (accept) begin
            if (wrStripEnd) begin
                col    <= '0;
                line   <= '0;
                wBank  <= ~wBank;
                wStrip <= (wStripEff == SC_W'(stripsPerFrame - 1)) ? '0 : wStripEff + SC_W'(1);
            end else if (colEff == COL_W'(IMG_WIDTH - 1)) begin
                col    <= '0;
                line   <= lineEff + LINE_W'(1);
                wStrip <= wStripEff;
            end else begin
                col    <= colEff + COL_W'(1);
                line   <= lineEff;
                wStrip <= wStripEff;
            end
            if (bus.iSof && (!posZero || (wStrip != '0))) begin
                sofErr <= 1'b1;
            end
        end
    end

    // Fill and release of the two banks; set and clear never collide on one bank
    always_comb begin
        bankFullNext = bankFull;
        if (accept && wrStripEnd) begin
            bankFullNext[wBank] = 1'b1;
        end
        if (rdFinal) begin
            bankFullNext[rBank] = 1'b0;
        end
    end

    // Bank occupancy register
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            bankFull <= '0;
        end else begin
            bankFull <= bankFullNext;
        end
    end

    assign rdEn      = (rState == R_ACTIVE) && bus.iOutReady;
    assign rdFinal   = rdEn && stripLast;
    assign frameLast = stripLast && (rStrip == SC_W'(stripsPerFrame - 1));

    assign bus.oRdEn = rdEn;

    tile_rd_addr_gen #(
        .IMG_WIDTH  (IMG_WIDTH),
        .TILE_WIDTH (TILE_WIDTH),
        .TILE_HEIGHT(TILE_HEIGHT),
        .ADDR_W     (ADDR_W)
    ) u_rdAddrGen (
        .iClk      (iClk),
        .iRst      (iRst),
        .iAdvance  (rdEn),
        .iBank     (rBank),
        .oRdAddr   (bus.oRdAddr),
        .oTileStart(tileStart),
        .oTileLast (tileLast),
        .oStripLast(stripLast)
    );

    // Read FSM: wait for a full bank, drain it in tile order, hand it back
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            rState <= R_IDLE;
            rBank  <= 1'b0;
            rStrip <= '0;
        end else begin
            case (rState)
                R_IDLE: begin
                    if (bankFull[rBank]) begin
                        rState <= R_ACTIVE;
                    end
                end
                R_ACTIVE: begin
                    if (rdFinal) begin
                        rState <= R_IDLE;
                        rBank  <= ~rBank;
                        rStrip <= (rStrip == SC_W'(stripsPerFrame - 1)) ? '0 : rStrip + SC_W'(1);
                    end
                end
                default: rState <= R_IDLE;
            endcase
        end
    end

    // Align read framing with BRAM output data
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            for (int i = 0; i < int'(RD_LATENCY); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {rdEn, rdEn && tileStart, rdEn && tileLast, rdEn && frameLast};
            for (int i = 1; i < int'(RD_LATENCY); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {bus.oRdValid, bus.oTileStart, bus.oTileLast, bus.oFrameDone} = pipe[RD_LATENCY-1];

endmodule

// File: tb/tb_strip_tile_scheduler.sv
// Scoreboard bench for strip_tile_scheduler on a reduced 64x64 frame geometry.
module tb_strip_tile_scheduler;

    localparam int unsigned W      = 64;
    localparam int unsigned H      = 64;
    localparam int unsigned TW     = 16;
    localparam int unsigned TH     = 16;
    localparam int unsigned LAT    = 2;
    localparam int unsigned AW     = 11;
    localparam int          STRIPN = W * TH;
    localparam int          TPSN   = W / TW;
    localparam int          SPFN   = H / TH;

    typedef struct {
        int addr;
        int bank;
        bit ts;
        bit tl;
        bit sl;
    } rdEnt_t;

    typedef struct {
        int addr;
        bit ts;
        bit tl;
        bit fd;
        int due;
    } vEnt_t;

    logic iClk = 1'b0;
    logic iRst = 1'b0;

    strip_tile_scheduler_if #(.ADDR_W(AW)) bus ();

    strip_tile_scheduler #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .TILE_WIDTH (TW),
        .TILE_HEIGHT(TH),
        .RD_LATENCY (LAT),
        .ADDR_W     (AW)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .bus (bus)
    );

    always #5 iClk = ~iClk;

    rdEnt_t rdQ[$];
    vEnt_t  vQ[$];
    int     checks = 0;
    int     passes = 0;
    int     cyc = 0;
    bit     fullM[2];
    int     wBankM, wPosM, wStripM, rStripM;
    bit     sofErrM;
    int     accCnt, rdEnCnt, rvCnt, tsCnt, tlCnt, fdCnt, fdAddr, lastStripAddr;

    task automatic modelClear();
        rdQ.delete();
        vQ.delete();
        fullM[0] = 0; fullM[1] = 0;
        wBankM = 0; wPosM = 0; wStripM = 0; rStripM = 0; sofErrM = 0;
        accCnt = 0; rdEnCnt = 0; rvCnt = 0; tsCnt = 0; tlCnt = 0; fdCnt = 0;
        fdAddr = -1; lastStripAddr = -1;
    endtask

    // Expected tile-order reads of one completed bank
    task automatic pushStrip(input int bank);
        rdEnt_t e;
        for (int tx = 0; tx < TPSN; tx++)
            for (int r = 0; r < int'(TH); r++)
                for (int c = 0; c < int'(TW); c++) begin
                    e.addr = bank * STRIPN + r * int'(W) + tx * int'(TW) + c;
                    e.bank = bank;
                    e.ts   = (r == 0) && (c == 0);
                    e.tl   = (r == int'(TH) - 1) && (c == int'(TW) - 1);
                    e.sl   = e.tl && (tx == TPSN - 1);
                    rdQ.push_back(e);
                end
    endtask

    // One clock: drive inputs, score every output against the model at the falling edge
    task automatic tick(input bit pv, input bit sof, input bit ordy);
        bit     expReady, acc, vDue;
        rdEnt_t e;
        vEnt_t  v;
        bus.iPixValid = pv;
        bus.iSof      = sof;
        bus.iOutReady = ordy;
        @(negedge iClk);

        while (vQ.size() > 0 && vQ[0].due < cyc) begin
            checks++;
            $display("FAIL rdValidMissed cyc=%0d addr=%0d due=%0d", cyc, vQ[0].addr, vQ[0].due);
            void'(vQ.pop_front());
        end
        vDue = (vQ.size() > 0) && (vQ[0].due == cyc);
        checks++;
        if (bus.oRdValid !== vDue) $display("FAIL rdValid cyc=%0d got=%b exp=%b", cyc, bus.oRdValid, vDue);
        else passes++;
        tsCnt += int'(bus.oTileStart === 1'b1);
        tlCnt += int'(bus.oTileLast === 1'b1);
        fdCnt += int'(bus.oFrameDone === 1'b1);
        if (vDue) begin
            v = vQ.pop_front();
            rvCnt++;
            if (bus.oFrameDone === 1'b1) fdAddr = v.addr;
            checks++;
            if ({bus.oTileStart, bus.oTileLast, bus.oFrameDone} !== {v.ts, v.tl, v.fd})
                $display("FAIL rdTags cyc=%0d addr=%0d got=%b%b%b exp=%b%b%b", cyc, v.addr,
                         bus.oTileStart, bus.oTileLast, bus.oFrameDone, v.ts, v.tl, v.fd);
            else passes++;
        end else begin
            checks++;
            if ({bus.oTileStart, bus.oTileLast, bus.oFrameDone} !== 3'b000)
                $display("FAIL idleTags cyc=%0d got=%b%b%b exp=000", cyc,
                         bus.oTileStart, bus.oTileLast, bus.oFrameDone);
            else passes++;
        end

        expReady = !fullM[wBankM];
        checks++;
        if (bus.oPixReady !== expReady) $display("FAIL pixReady cyc=%0d got=%b exp=%b", cyc, bus.oPixReady, expReady);
        else passes++;
        acc = pv && expReady;
        checks++;
        if (bus.oWrEn !== acc) $display("FAIL wrEn cyc=%0d got=%b exp=%b", cyc, bus.oWrEn, acc);
        else passes++;
        checks++;
        if (bus.oSofErr !== sofErrM) $display("FAIL sofErr cyc=%0d got=%b exp=%b", cyc, bus.oSofErr, sofErrM);
        else passes++;
        if (acc) begin
            if (sof) begin
                if (wPosM != 0 || wStripM != 0) sofErrM = 1;
                wPosM = 0;
                wStripM = 0;
            end
            checks++;
            if (bus.oWrAddr !== AW'(wBankM * STRIPN + wPosM))
                $display("FAIL wrAddr cyc=%0d got=%0d exp=%0d", cyc, bus.oWrAddr, wBankM * STRIPN + wPosM);
            else passes++;
            accCnt++;
            wPosM++;
            if (wPosM == STRIPN) begin
                fullM[wBankM] = 1;
                pushStrip(wBankM);
                wBankM  = 1 - wBankM;
                wPosM   = 0;
                wStripM = (wStripM + 1) % SPFN;
            end
        end

        if (bus.oRdEn === 1'b1) begin
            rdEnCnt++;
            checks++;
            if (!ordy) $display("FAIL rdEnNoReady cyc=%0d got=1 exp=0", cyc);
            else passes++;
            checks++;
            if (rdQ.size() == 0) begin
                $display("FAIL rdUnexpected cyc=%0d got addr=%0d exp=none", cyc, bus.oRdAddr);
            end else begin
                e = rdQ.pop_front();
                if (bus.oRdAddr !== AW'(e.addr))
                    $display("FAIL rdAddr cyc=%0d got=%0d exp=%0d", cyc, bus.oRdAddr, e.addr);
                else passes++;
                v.addr = e.addr;
                v.ts   = e.ts;
                v.tl   = e.tl;
                v.fd   = e.sl && (rStripM == SPFN - 1);
                v.due  = cyc + int'(LAT);
                vQ.push_back(v);
                if (e.sl) begin
                    fullM[e.bank] = 0;
                    rStripM = (rStripM + 1) % SPFN;
                    lastStripAddr = e.addr;
                end
            end
        end

        cyc++;
        @(posedge iClk);
        #1;
    endtask

    task automatic doReset();
        bus.iPixValid = 0;
        bus.iSof      = 0;
        bus.iOutReady = 0;
        iRst = 0;
        repeat (2) @(posedge iClk);
        #1;
        iRst = 1;
        modelClear();
    endtask

    // Idle the source and let the reader empty every pending bank
    task automatic drain(input int mode);
        int n = 0;
        bit r;
        while ((rdQ.size() > 0 || vQ.size() > 0) && n < 6 * STRIPN) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(n % 2 == 0) : bit'($urandom_range(0, 1));
            tick(0, 0, r);
            n++;
        end
        checks++;
        if (rdQ.size() > 0 || vQ.size() > 0)
            $display("FAIL drainTimeout got pending=%0d/%0d exp=0/0", rdQ.size(), vQ.size());
        else passes++;
        repeat (4) tick(0, 0, 1);
    endtask

    task automatic test_reset();
        bus.iPixValid = 0;
        bus.iSof      = 0;
        bus.iOutReady = 0;
        iRst = 0;
        repeat (2) @(posedge iClk);
        #1;
        checks++; if (bus.oPixReady !== 1'b1)  $display("FAIL rst_pixReady got=%b exp=1", bus.oPixReady); else passes++;
        checks++; if (bus.oWrEn !== 1'b0)      $display("FAIL rst_wrEn got=%b exp=0", bus.oWrEn); else passes++;
        checks++; if (bus.oWrAddr !== '0)      $display("FAIL rst_wrAddr got=%0d exp=0", bus.oWrAddr); else passes++;
        checks++; if (bus.oRdEn !== 1'b0)      $display("FAIL rst_rdEn got=%b exp=0", bus.oRdEn); else passes++;
        checks++; if (bus.oRdAddr !== '0)      $display("FAIL rst_rdAddr got=%0d exp=0", bus.oRdAddr); else passes++;
        checks++; if (bus.oRdValid !== 1'b0)   $display("FAIL rst_rdValid got=%b exp=0", bus.oRdValid); else passes++;
        checks++; if (bus.oTileStart !== 1'b0) $display("FAIL rst_tileStart got=%b exp=0", bus.oTileStart); else passes++;
        checks++; if (bus.oTileLast !== 1'b0)  $display("FAIL rst_tileLast got=%b exp=0", bus.oTileLast); else passes++;
        checks++; if (bus.oFrameDone !== 1'b0) $display("FAIL rst_frameDone got=%b exp=0", bus.oFrameDone); else passes++;
        checks++; if (bus.oSofErr !== 1'b0)    $display("FAIL rst_sofErr got=%b exp=0", bus.oSofErr); else passes++;
        iRst = 1;
        modelClear();
        repeat (4) tick(0, 0, 1);
    endtask

    task automatic test_single_strip();
        doReset();
        tick(1, 1, 1);
        for (int i = 1; i < STRIPN; i++) tick(1, 0, 1);
        drain(0);
        checks++; if (bus.oSofErr !== 1'b0) $display("FAIL strip_sofErr got=%b exp=0", bus.oSofErr); else passes++;
        checks++; if (rvCnt != STRIPN)      $display("FAIL strip_beats got=%0d exp=%0d", rvCnt, STRIPN); else passes++;
        checks++; if (tsCnt != TPSN)        $display("FAIL strip_tileStarts got=%0d exp=%0d", tsCnt, TPSN); else passes++;
        checks++; if (tlCnt != TPSN)        $display("FAIL strip_tileLasts got=%0d exp=%0d", tlCnt, TPSN); else passes++;
    endtask

    task automatic test_backpressure();
        int n = 0;
        doReset();
        for (int i = 0; i < 2 * STRIPN + 20; i++) tick(1, 0, 0);
        checks++; if (accCnt != 2 * STRIPN)  $display("FAIL bp_accepts got=%0d exp=%0d", accCnt, 2 * STRIPN); else passes++;
        checks++; if (bus.oPixReady !== 1'b0) $display("FAIL bp_pixReadyLow got=%b exp=0", bus.oPixReady); else passes++;
        checks++; if (rdEnCnt != 0)           $display("FAIL bp_noReads got=%0d exp=0", rdEnCnt); else passes++;
        while (fullM[0] && n < 2 * STRIPN) begin
            tick(0, 0, 1);
            n++;
        end
        checks++; if (lastStripAddr != STRIPN - 1) $display("FAIL bp_bank0Final got=%0d exp=%0d", lastStripAddr, STRIPN - 1); else passes++;
        checks++; if (bus.oPixReady !== 1'b1)      $display("FAIL bp_pixReadyBack got=%b exp=1", bus.oPixReady); else passes++;
        drain(0);
        checks++; if (rvCnt != 2 * STRIPN) $display("FAIL bp_beats got=%0d exp=%0d", rvCnt, 2 * STRIPN); else passes++;
    endtask

    task automatic test_full_frame();
        int n = 0;
        doReset();
        tick(1, 1, 1);
        while (accCnt < SPFN * STRIPN && n < 40000) begin
            tick(bit'($urandom_range(0, 3) != 0), 0, bit'($urandom_range(0, 1)));
            n++;
        end
        drain(2);
        checks++; if (accCnt != SPFN * STRIPN)    $display("FAIL frame_accepts got=%0d exp=%0d", accCnt, SPFN * STRIPN); else passes++;
        checks++; if (rvCnt != SPFN * STRIPN)     $display("FAIL frame_beats got=%0d exp=%0d", rvCnt, SPFN * STRIPN); else passes++;
        checks++; if (tlCnt != TPSN * SPFN)       $display("FAIL frame_tileLasts got=%0d exp=%0d", tlCnt, TPSN * SPFN); else passes++;
        checks++; if (fdCnt != 1)                 $display("FAIL frame_doneCount got=%0d exp=1", fdCnt); else passes++;
        checks++; if (fdAddr != 2 * STRIPN - 1)   $display("FAIL frame_doneAddr got=%0d exp=%0d", fdAddr, 2 * STRIPN - 1); else passes++;
    endtask

    task automatic test_sof();
        doReset();
        for (int i = 0; i < 3 * int'(W) + 40; i++) tick(1, 0, 1);
        tick(1, 1, 1);
        checks++; if (bus.oSofErr !== 1'b1) $display("FAIL sof_errSet got=%b exp=1", bus.oSofErr); else passes++;
        for (int i = 1; i < STRIPN; i++) tick(1, 0, 1);
        drain(0);
        checks++; if (bus.oSofErr !== 1'b1) $display("FAIL sof_errHeld got=%b exp=1", bus.oSofErr); else passes++;
        checks++; if (rvCnt != STRIPN)      $display("FAIL sof_beats got=%0d exp=%0d", rvCnt, STRIPN); else passes++;
    endtask

    task automatic test_reset_mid();
        doReset();
        for (int i = 0; i < STRIPN + 7 * int'(W) + 5; i++) tick(1, 0, 1);
        #2;
        bus.iPixValid = 0;
        iRst = 0;
        #1;
        checks++; if (bus.oPixReady !== 1'b1)  $display("FAIL mid_pixReady got=%b exp=1", bus.oPixReady); else passes++;
        checks++; if (bus.oWrEn !== 1'b0)      $display("FAIL mid_wrEn got=%b exp=0", bus.oWrEn); else passes++;
        checks++; if (bus.oWrAddr !== '0)      $display("FAIL mid_wrAddr got=%0d exp=0", bus.oWrAddr); else passes++;
        checks++; if (bus.oRdEn !== 1'b0)      $display("FAIL mid_rdEn got=%b exp=0", bus.oRdEn); else passes++;
        checks++; if (bus.oRdValid !== 1'b0)   $display("FAIL mid_rdValid got=%b exp=0", bus.oRdValid); else passes++;
        checks++; if ({bus.oTileStart, bus.oTileLast, bus.oFrameDone} !== 3'b000)
            $display("FAIL mid_tags got=%b%b%b exp=000", bus.oTileStart, bus.oTileLast, bus.oFrameDone); else passes++;
        @(posedge iClk);
        #1;
        iRst = 1;
        modelClear();
        tick(1, 0, 1);
        repeat (20) tick(0, 0, 1);
        checks++; if (rvCnt != 0) $display("FAIL mid_strayBeats got=%0d exp=0", rvCnt); else passes++;
    endtask

    task automatic test_toggle_ready();
        doReset();
        for (int i = 0; i < STRIPN; i++) tick(1, 0, bit'(i % 2 == 0));
        drain(1);
        checks++; if (rdEnCnt != STRIPN) $display("FAIL toggle_reads got=%0d exp=%0d", rdEnCnt, STRIPN); else passes++;
        checks++; if (rvCnt != STRIPN)   $display("FAIL toggle_beats got=%0d exp=%0d", rvCnt, STRIPN); else passes++;
    endtask

    initial begin
        bus.iPixValid = 0;
        bus.iSof      = 0;
        bus.iOutReady = 0;
        modelClear();
        test_reset();
        test_single_strip();
        test_backpressure();
        test_full_frame();
        test_sof();
        test_reset_mid();
        test_toggle_ready();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
